// File: rtl/sr04_fmt_pkg.sv
// Shared types and constants for the SR04 distance-to-UART ASCII formatter.
// Holds the FSM encoding, the frame constants and the BCD/byte helper functions.
package sr04_fmt_pkg;

    localparam int FRAME_LEN = 8;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_C    = 8'h63;
    localparam logic [7:0] ASC_M    = 8'h6D;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } fmt_state_e;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (res[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [15:0]      digits);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASC_ZERO + {4'h0, digits[15:12]};
            3'd1:    b = ASC_ZERO + {4'h0, digits[11:8]};
            3'd2:    b = ASC_ZERO + {4'h0, digits[7:4]};
            3'd3:    b = ASC_ZERO + {4'h0, digits[3:0]};
            3'd4:    b = ASC_C;
            3'd5:    b = ASC_M;
            3'd6:    b = ASC_CR;
            default: b = ASC_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a DIST_W-bit binary value to 4 BCD digits,
// one input bit per clock, with a one-cycle done pulse when the digits are valid.
module bin2bcd_seq
    import sr04_fmt_pkg::*;
#(
    parameter int DIST_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DIST_W-1:0] bin_i,
    output logic              done_o,
    output logic [15:0]       bcd_o
);

    localparam int CNT_W = $clog2(DIST_W + 1);

    logic [DIST_W-1:0] bin_q;
    logic [15:0]       bcd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;
    logic [15+DIST_W:0] shifted;

    always_comb begin
        shifted = {bcd_adjust(bcd_q), bin_q} << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the shift datapath is small and reset anyway so a stale
            // conversion can never leak into a frame after reset.
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DIST_W);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                // NOTE: non-blocking so both halves of the shift see the
                // pre-edge value of the combined register.
                {bcd_q, bin_q} <= shifted;
                cnt_q          <= cnt_q - 1'b1;
            end else begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/sr04_dist_uart_fmt.sv
// Formats each SR04 distance result as "ddddcm\r\n" and streams it to the UART
// transmitter over a start/busy handshake, with a one-deep pending buffer.
module sr04_dist_uart_fmt
    import sr04_fmt_pkg::*;
#(
    parameter int DIST_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] distance,
    input  logic              dist_done,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              overrun
);

    fmt_state_e        state_q;
    logic [DIST_W-1:0] pend_q;
    logic              pend_valid_q;
    logic [IDX_W-1:0]  idx_q;
    logic [15:0]       digits_q;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic              overrun_q;

    logic              conv_start;
    logic [DIST_W-1:0] conv_value;
    logic              conv_done;
    logic [15:0]       conv_bcd;

    // A fresh measurement in IDLE wins over a pending one; the pending value
    // stays buffered and is framed afterwards.
    always_comb begin
        conv_start = (state_q == ST_IDLE) && (dist_done || pend_valid_q);
        conv_value = dist_done ? distance : pend_q;
    end

    bin2bcd_seq #(
        .DIST_W (DIST_W)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (conv_value),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            idx_q        <= '0;
            digits_q     <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;

            // Measurements arriving mid-frame (including the cycle that ends it)
            // are buffered; the frame in progress is never touched.
            if (dist_done && state_q != ST_IDLE) begin
                pend_q       <= distance;
                pend_valid_q <= 1'b1;
                if (pend_valid_q) begin
                    overrun_q <= 1'b1;
                end
            end else if (state_q == ST_IDLE && !dist_done && pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (conv_start) begin
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        digits_q  <= conv_bcd;
                        idx_q     <= '0;
                        tx_data_q <= frame_byte('0, conv_bcd);
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    tx_start_q <= 1'b0;
                    state_q    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            tx_data_q <= frame_byte(idx_q + 1'b1, digits_q);
                            state_q   <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = overrun_q;

endmodule

// File: doc/sr04_dist_uart_fmt.md
Name: sr04_dist_uart_fmt

Overview:
Downstream consumer of the ultrasonic controller's distance result. On each dist_done pulse it captures the 11-bit distance in cm and converts it to 4 BCD digits with a sequential shift-add-3. It then streams an 8-byte ASCII frame "dddd" "cm" CR LF to the shared UART transmitter through a start/busy handshake. It sits beside the FND controller on the distance/dist_done bus, between the distance controller and the UART TX.

Parameters:
DIST_W, 11, width of the distance input in cm; max value 2047, so always 4 decimal digits.
FRAME_LEN, 8, bytes per frame; fixed, not for override.

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous, active-low reset
distance  input  DIST_W  distance in cm; valid in the cycle dist_done is high
dist_done  input  1  one-cycle pulse marking a new measurement
tx_busy  input  1  UART transmitter busy; high from the cycle after tx_start until the byte is sent
tx_start  output  1  one-cycle request to the UART to send tx_data
tx_data  output  8  byte to transmit; stable from tx_start until tx_busy falls
busy  output  1  high whenever the FSM is not in IDLE
overrun  output  1  one-cycle pulse when a pending, unsent measurement is overwritten

Behaviour:
- Reset (rst=0, asynchronous): FSM = IDLE. tx_start=0, tx_data=8'h00, busy=0, overrun=0. Pending register is cleared and pending_valid=0. The conversion datapath is cleared. Reset mid-frame abandons the frame immediately and sends no further bytes.
- FSM states: IDLE, CONV, LOAD, START, WAIT_ACK, WAIT_DONE.
- IDLE: if dist_done, capture distance and go to CONV. Otherwise, if pending_valid, take the pending value, clear pending_valid and go to CONV.
- CONV: 11-iteration double-dabble, one bit per cycle, with add-3 on any digit ≥5 before each shift. After exactly DIST_W cycles, latch digits d3..d0 and go to LOAD with byte index 0.
- LOAD: drive tx_data from the byte index:
  - index 0..3: 8'h30 + d3..d0
  - index 4: 8'h63 ('c')
  - index 5: 8'h6D ('m')
  - index 6: 8'h0D (CR)
  - index 7: 8'h0A (LF)
  If tx_busy=0, go to START; otherwise hold in LOAD.
- START: tx_start=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0. If index=7, go to IDLE. Otherwise increment the index and go to LOAD.
- Leading zeros are transmitted ("0005"). Distance 0 gives "0000cm\r\n".
- Latency: with dist_done sampled at clock edge N in IDLE and tx_busy=0, tx_start is high in the cycle after edge N+13 (1 capture + 11 conversion + 1 LOAD).
- dist_done while busy (any non-IDLE state): the distance is stored in the one-deep pending register and pending_valid=1. If pending_valid was already 1, the new value overwrites it and overrun pulses for one cycle. The frame in progress is never disturbed.
- dist_done in the same cycle the FSM returns to IDLE: the value goes to pending and is framed next. There is no loss and no overrun.
- tx_data holds its value from LOAD through WAIT_DONE.
- tx_start is never asserted while tx_busy=1.

Decomposition:
- Package sr04_fmt_pkg holds:
  - the FSM state encoding;
  - FRAME_LEN;
  - ASCII constants ASC_ZERO=8'h30, ASC_C=8'h63, ASC_M=8'h6D, ASC_CR=8'h0D, ASC_LF=8'h0A.
- One sub-module, bin2bcd_seq: start/done sequential double-dabble, DIST_W-bit input, 16-bit BCD output, same clk/rst.
- The top module contains the FSM, the pending register and the byte mux.

Test Plan:
- distance=123 with a dist_done pulse; UART model raises busy 1 cycle after start for 20 cycles -> bytes 30 31 32 33 63 6D 0D 0A in order; first tx_start 13 cycles after dist_done; busy falls after the last byte.
- distance=2047 -> 32 30 34 37 63 6D 0D 0A. distance=0 -> 30 30 30 30 63 6D 0D 0A.
- During frame of 45: dist_done with 100, then with 200 -> exactly one overrun pulse (on 200); next frame carries "0200"; the 100 value is never sent.
- tx_busy held high for 50 cycles before the first byte -> tx_start stays 0 until tx_busy falls, then pulses once; tx_data is stable throughout each byte.
- rst low during byte 3 of a frame -> all outputs are 0 on the next sample; no tx_start after rst returns high; a new dist_done with 7 sends "0007cm\r\n" normally.
- dist_done coincident with the WAIT_DONE→IDLE transition of a frame -> the value is framed next, with no overrun pulse.
